// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared encodings for the 5-stage pipe controller: opcode constants,
// immediate/ALU/result/source-A selector enums, and the control bundles
// carried through the ID/EX, EX/MEM and MEM/WB registers.
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      SRCA_RS1  = 2'b00,
      SRCA_PC   = 2'b01,
      SRCA_ZERO = 2'b10
   } alu_src_a_t;

   typedef struct packed {
      logic        regwrite;
      result_src_t resultsrc;
      logic        memwrite;
      logic        jump;
      logic        branch;
      alu_ctrl_t   alucontrol;
      alu_src_a_t  alusrca;
      logic        alusrcb;
      logic        pctgtsrc;
      logic [2:0]  funct3;
      logic        illegal;
   } ctrl_e_t;

   typedef struct packed {
      logic        regwrite;
      result_src_t resultsrc;
      logic        memwrite;
      logic [2:0]  funct3;
      logic        illegal;
   } ctrl_m_t;

   typedef struct packed {
      logic        regwrite;
      result_src_t resultsrc;
      logic        illegal;
   } ctrl_w_t;

   // All-zero bundle: a NOP bubble in any stage.
   localparam ctrl_e_t CTRL_BUBBLE = '0;

   // funct3 -> ALU operation; alt selects SUB (funct3 000) or SRA (funct3 101).
   function automatic alu_ctrl_t alu_op(input logic [2:0] funct3, input logic alt);
      alu_ctrl_t res;
      case (funct3)
         3'b000:  res = alt ? ALU_SUB : ALU_ADD;
         3'b001:  res = ALU_SLL;
         3'b010:  res = ALU_SLT;
         3'b011:  res = ALU_SLTU;
         3'b100:  res = ALU_XOR;
         3'b101:  res = alt ? ALU_SRA : ALU_SRL;
         3'b110:  res = ALU_OR;
         3'b111:  res = ALU_AND;
         default: res = ALU_ADD;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/pipe_controller_main_dec.sv
// ---------------------------------------------------------------------------
// main_dec
// Combinational decode of op/funct3/funct7b5 into the E-stage control bundle
// and the immediate-format select. Unrecognised encodings produce a bundle
// with only the illegal flag set and immsrc = I.
// Ports:
//   op       in  7  instr[6:0]
//   funct3   in  3  instr[14:12]
//   funct7b5 in  1  instr[30]
//   ctrl     out    ctrl_e_t bundle for the ID/EX register
//   immsrc   out 3  immediate format select
// ---------------------------------------------------------------------------
module main_dec
   import riscv_pkg::*;
(
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output ctrl_e_t    ctrl,
   output imm_src_t   immsrc
);

   logic bad;

   // Opcode decode, then override with a flagged bubble if the encoding is illegal.
   always_comb begin
      ctrl        = CTRL_BUBBLE;
      immsrc      = IMM_I;
      bad         = 1'b0;
      ctrl.funct3 = funct3;
      case (op)
         OP_R: begin
            ctrl.regwrite   = 1'b1;
            ctrl.alucontrol = alu_op(funct3, funct7b5);
            // only add/sub and srl/sra have a funct7b5 variant
            bad = funct7b5 & (funct3 != 3'b000) & (funct3 != 3'b101);
         end
         OP_I: begin
            ctrl.regwrite   = 1'b1;
            ctrl.alusrcb    = 1'b1;
            // addi has no subtract form, so funct7b5 only matters for shifts
            ctrl.alucontrol = alu_op(funct3, funct7b5 & (funct3 == 3'b101));
            bad = funct7b5 & (funct3 == 3'b001);
         end
         OP_LOAD: begin
            ctrl.regwrite  = 1'b1;
            ctrl.resultsrc = RES_MEM;
            ctrl.alusrcb   = 1'b1;
         end
         OP_STORE: begin
            ctrl.memwrite = 1'b1;
            ctrl.alusrcb  = 1'b1;
            immsrc        = IMM_S;
         end
         OP_BRANCH: begin
            ctrl.branch     = 1'b1;
            ctrl.alucontrol = ALU_SUB;
            immsrc          = IMM_B;
            bad = (funct3 == 3'b010) | (funct3 == 3'b011);
         end
         OP_JAL: begin
            ctrl.regwrite  = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.resultsrc = RES_PC4;
            immsrc         = IMM_J;
         end
         OP_JALR: begin
            ctrl.regwrite  = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.resultsrc = RES_PC4;
            ctrl.alusrcb   = 1'b1;
            ctrl.pctgtsrc  = 1'b1;
         end
         OP_LUI: begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrca  = SRCA_ZERO;
            ctrl.alusrcb  = 1'b1;
            immsrc        = IMM_U;
         end
         OP_AUIPC: begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrca  = SRCA_PC;
            ctrl.alusrcb  = 1'b1;
            immsrc        = IMM_U;
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         ctrl         = CTRL_BUBBLE;
         ctrl.illegal = 1'b1;
         immsrc       = IMM_I;
      end else begin
         ctrl.illegal = 1'b0;
      end
   end

endmodule

// File: rtl/pipe_controller.sv
// ---------------------------------------------------------------------------
// pipe_controller
// Control unit for the 5-stage pipe: decodes in D, carries control through
// ID/EX, EX/MEM and MEM/WB, and resolves branch/jump redirect in E.
// Ports:
//   clk, reset (sync, active-high)
//   op_d, funct3_d, funct7b5_d       instruction fields in D
//   flush_e                          bubble into E at next edge
//   zero_e, lt_e, ltu_e              ALU compare flags in E
//   immsrc_d, illegal_d              combinational D-stage decode
//   alucontrol_e, alusrca_e, alusrcb_e, pcsrc_e, pctgtsrc_e, resultsrc_e
//   regwrite_m, memwrite_m, funct3_m
//   regwrite_w, resultsrc_w, illegal_w
// ---------------------------------------------------------------------------
module pipe_controller
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op_d,
   input  logic [2:0] funct3_d,
   input  logic       funct7b5_d,
   input  logic       flush_e,
   input  logic       zero_e,
   input  logic       lt_e,
   input  logic       ltu_e,
   output logic [2:0] immsrc_d,
   output logic       illegal_d,
   output logic [3:0] alucontrol_e,
   output logic [1:0] alusrca_e,
   output logic       alusrcb_e,
   output logic       pcsrc_e,
   output logic       pctgtsrc_e,
   output logic [1:0] resultsrc_e,
   output logic       regwrite_m,
   output logic       memwrite_m,
   output logic [2:0] funct3_m,
   output logic       regwrite_w,
   output logic [1:0] resultsrc_w,
   output logic       illegal_w
);

   ctrl_e_t  ctrl_d;
   imm_src_t immsrc;
   ctrl_e_t  ctrl_e_r;
   ctrl_m_t  ctrl_m_r;
   ctrl_w_t  ctrl_w_r;
   logic     taken;

   main_dec u_main_dec (
      .op       (op_d),
      .funct3   (funct3_d),
      .funct7b5 (funct7b5_d),
      .ctrl     (ctrl_d),
      .immsrc   (immsrc)
   );

   assign immsrc_d  = immsrc;
   assign illegal_d = ctrl_d.illegal;

   // ID/EX register: reset beats flush, both insert a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_e_r <= CTRL_BUBBLE;
      end else if (flush_e) begin
         ctrl_e_r <= CTRL_BUBBLE;
      end else begin
         ctrl_e_r <= ctrl_d;
      end
   end

   // EX/MEM and MEM/WB registers: always advance, cleared on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_m_r <= '0;
         ctrl_w_r <= '0;
      end else begin
         ctrl_m_r.regwrite  <= ctrl_e_r.regwrite;
         ctrl_m_r.resultsrc <= ctrl_e_r.resultsrc;
         ctrl_m_r.memwrite  <= ctrl_e_r.memwrite;
         ctrl_m_r.funct3    <= ctrl_e_r.funct3;
         ctrl_m_r.illegal   <= ctrl_e_r.illegal;
         ctrl_w_r.regwrite  <= ctrl_m_r.regwrite;
         ctrl_w_r.resultsrc <= ctrl_m_r.resultsrc;
         ctrl_w_r.illegal   <= ctrl_m_r.illegal;
      end
   end

   // Branch condition from funct3; 010/011 never arrive here as a branch.
   always_comb begin
      taken = 1'b0;
      case (ctrl_e_r.funct3)
         3'b000:  taken = zero_e;
         3'b001:  taken = ~zero_e;
         3'b100:  taken = lt_e;
         3'b101:  taken = ~lt_e;
         3'b110:  taken = ltu_e;
         3'b111:  taken = ~ltu_e;
         default: taken = 1'b0;
      endcase
   end

   assign pcsrc_e      = ctrl_e_r.jump | (ctrl_e_r.branch & taken);
   assign alucontrol_e = ctrl_e_r.alucontrol;
   assign alusrca_e    = ctrl_e_r.alusrca;
   assign alusrcb_e    = ctrl_e_r.alusrcb;
   assign pctgtsrc_e   = ctrl_e_r.pctgtsrc;
   assign resultsrc_e  = ctrl_e_r.resultsrc;
   assign regwrite_m   = ctrl_m_r.regwrite;
   assign memwrite_m   = ctrl_m_r.memwrite;
   assign funct3_m     = ctrl_m_r.funct3;
   assign regwrite_w   = ctrl_w_r.regwrite;
   assign resultsrc_w  = ctrl_w_r.resultsrc;
   assign illegal_w    = ctrl_w_r.illegal;

endmodule

// File: tb/tb_pipe_controller.sv
// ---------------------------------------------------------------------------
// tb_pipe_controller
// Directed and randomized stimulus for pipe_controller, checked against a
// behavioural model: a decode table function plus a three-entry stage model.
// ---------------------------------------------------------------------------
module tb_pipe_controller;

   localparam logic [6:0] T_R  = 7'b0110011;
   localparam logic [6:0] T_I  = 7'b0010011;
   localparam logic [6:0] T_LD = 7'b0000011;
   localparam logic [6:0] T_ST = 7'b0100011;
   localparam logic [6:0] T_BR = 7'b1100011;
   localparam logic [6:0] T_JL = 7'b1101111;
   localparam logic [6:0] T_JR = 7'b1100111;
   localparam logic [6:0] T_LU = 7'b0110111;
   localparam logic [6:0] T_AU = 7'b0010111;

   typedef struct packed {
      logic       rw;
      logic [1:0] rs;
      logic       mw;
      logic       jmp;
      logic       br;
      logic [3:0] alu;
      logic [1:0] sa;
      logic       sb;
      logic       tgt;
      logic [2:0] f3;
      logic       ill;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [6:0] op_d;
   logic [2:0] funct3_d;
   logic       funct7b5_d;
   logic       flush_e;
   logic       zero_e;
   logic       lt_e;
   logic       ltu_e;
   logic [2:0] immsrc_d;
   logic       illegal_d;
   logic [3:0] alucontrol_e;
   logic [1:0] alusrca_e;
   logic       alusrcb_e;
   logic       pcsrc_e;
   logic       pctgtsrc_e;
   logic [1:0] resultsrc_e;
   logic       regwrite_m;
   logic       memwrite_m;
   logic [2:0] funct3_m;
   logic       regwrite_w;
   logic [1:0] resultsrc_w;
   logic       illegal_w;

   int   checks = 0;
   int   errors = 0;
   exp_t s_e, s_m, s_w;
   logic [2:0] imm_seen;
   logic       ill_seen;
   logic       pcsrc_seen;
   logic [6:0] op_pool [10];

   pipe_controller dut (
      .clk          (clk),
      .reset        (reset),
      .op_d         (op_d),
      .funct3_d     (funct3_d),
      .funct7b5_d   (funct7b5_d),
      .flush_e      (flush_e),
      .zero_e       (zero_e),
      .lt_e         (lt_e),
      .ltu_e        (ltu_e),
      .immsrc_d     (immsrc_d),
      .illegal_d    (illegal_d),
      .alucontrol_e (alucontrol_e),
      .alusrca_e    (alusrca_e),
      .alusrcb_e    (alusrcb_e),
      .pcsrc_e      (pcsrc_e),
      .pctgtsrc_e   (pctgtsrc_e),
      .resultsrc_e  (resultsrc_e),
      .regwrite_m   (regwrite_m),
      .memwrite_m   (memwrite_m),
      .funct3_m     (funct3_m),
      .regwrite_w   (regwrite_w),
      .resultsrc_w  (resultsrc_w),
      .illegal_w    (illegal_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      if (op == T_R)  return !f7 || f3 == 3'd0 || f3 == 3'd5;
      if (op == T_I)  return !(f7 && f3 == 3'd1);
      if (op == T_BR) return f3 != 3'd2 && f3 != 3'd3;
      return op == T_LD || op == T_ST || op == T_JL || op == T_JR || op == T_LU || op == T_AU;
   endfunction

   // Expected E-stage bundle for an instruction decoded in D.
   function automatic exp_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      exp_t e;
      logic [31:0] tbl;
      e = '0;
      if (!is_legal(op, f3, f7)) begin
         e.ill = 1'b1;
         return e;
      end
      e.f3 = f3;
      // nibble i holds the ALU code for funct3 = i: add sll slt sltu xor srl or and
      tbl = 32'h2384_6570;
      if (op == T_R || op == T_I) begin
         e.alu = tbl[f3*4 +: 4];
         if (op == T_R && f3 == 3'd0 && f7) e.alu = 4'd1;
         if (f3 == 3'd5 && f7)              e.alu = 4'd9;
      end
      if (op == T_BR) e.alu = 4'd1;
      e.rw  = op inside {T_R, T_I, T_LD, T_JL, T_JR, T_LU, T_AU};
      e.mw  = op == T_ST;
      e.br  = op == T_BR;
      e.jmp = op == T_JL || op == T_JR;
      e.tgt = op == T_JR;
      e.sb  = op inside {T_I, T_LD, T_ST, T_JR, T_LU, T_AU};
      e.sa  = (op == T_LU) ? 2'd2 : (op == T_AU) ? 2'd1 : 2'd0;
      e.rs  = (op == T_LD) ? 2'd1 : e.jmp ? 2'd2 : 2'd0;
      return e;
   endfunction

   function automatic logic [2:0] ref_imm(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      if (!is_legal(op, f3, f7)) return 3'd0;
      if (op == T_ST) return 3'd1;
      if (op == T_BR) return 3'd2;
      if (op == T_JL) return 3'd3;
      if (op == T_LU || op == T_AU) return 3'd4;
      return 3'd0;
   endfunction

   // Branch outcome: funct3[2:1] picks the flag, funct3[0] inverts it.
   function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic l, input logic u);
      logic c;
      case (f3[2:1])
         2'b00:   c = z;
         2'b10:   c = l;
         2'b11:   c = u;
         default: return 1'b0;
      endcase
      return c ^ f3[0];
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at the falling edge, check D/pcsrc, advance the model, check E/M/W.
   task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic fl, input logic rs,
                       input logic z, input logic l, input logic u);
      exp_t d;
      op_d = op; funct3_d = f3; funct7b5_d = f7;
      flush_e = fl; reset = rs;
      zero_e = z; lt_e = l; ltu_e = u;
      d = ref_decode(op, f3, f7);
      #1;
      chk("immsrc_d", {5'd0, immsrc_d}, {5'd0, ref_imm(op, f3, f7)});
      chk("illegal_d", {7'd0, illegal_d}, {7'd0, d.ill});
      chk("pcsrc_e", {7'd0, pcsrc_e}, {7'd0, s_e.jmp | (s_e.br & ref_taken(s_e.f3, z, l, u))});
      imm_seen   = immsrc_d;
      ill_seen   = illegal_d;
      pcsrc_seen = pcsrc_e;
      @(posedge clk);
      if (rs) begin
         s_e = '0; s_m = '0; s_w = '0;
      end else begin
         s_w = s_m;
         s_m = s_e;
         s_e = fl ? '0 : d;
      end
      @(negedge clk);
      chk("alucontrol_e", {4'd0, alucontrol_e}, {4'd0, s_e.alu});
      chk("alusrca_e",    {6'd0, alusrca_e},    {6'd0, s_e.sa});
      chk("alusrcb_e",    {7'd0, alusrcb_e},    {7'd0, s_e.sb});
      chk("pctgtsrc_e",   {7'd0, pctgtsrc_e},   {7'd0, s_e.tgt});
      chk("resultsrc_e",  {6'd0, resultsrc_e},  {6'd0, s_e.rs});
      chk("regwrite_m",   {7'd0, regwrite_m},   {7'd0, s_m.rw});
      chk("memwrite_m",   {7'd0, memwrite_m},   {7'd0, s_m.mw});
      chk("funct3_m",     {5'd0, funct3_m},     {5'd0, s_m.f3});
      chk("regwrite_w",   {7'd0, regwrite_w},   {7'd0, s_w.rw});
      chk("resultsrc_w",  {6'd0, resultsrc_w},  {6'd0, s_w.rs});
      chk("illegal_w",    {7'd0, illegal_w},    {7'd0, s_w.ill});
   endtask

   initial begin
      op_pool = '{T_R, T_I, T_LD, T_ST, T_BR, T_JL, T_JR, T_LU, T_AU, 7'd0};
      reset = 1'b1; op_d = 7'd0; funct3_d = 3'd0; funct7b5_d = 1'b0;
      flush_e = 1'b0; zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
      s_e = '0; s_m = '0; s_w = '0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_regwrite_w", {7'd0, regwrite_w}, 8'd0);
      chk("rst_memwrite_m", {7'd0, memwrite_m}, 8'd0);
      chk("rst_alucontrol_e", {4'd0, alucontrol_e}, 8'd0);

      // addi
      step(T_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("addi_imm", {5'd0, imm_seen}, 8'd0);
      chk("addi_alu", {4'd0, alucontrol_e}, 8'd0);
      chk("addi_srcb", {7'd0, alusrcb_e}, 8'd1);
      chk("addi_res", {6'd0, resultsrc_e}, 8'd0);
      step(T_ST, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(T_LD, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("addi_regwrite_w", {7'd0, regwrite_w}, 8'd1);

      // beq taken, bne not taken, bgeu taken
      step(T_BR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("beq_tgt", {7'd0, pctgtsrc_e}, 8'd0);
      step(T_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("beq_pcsrc", {7'd0, pcsrc_seen}, 8'd1);
      step(T_BR, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(T_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("bne_pcsrc", {7'd0, pcsrc_seen}, 8'd0);
      step(T_BR, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(T_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bgeu_pcsrc", {7'd0, pcsrc_seen}, 8'd1);

      // lui, auipc, jalr
      step(T_LU, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lui_imm", {5'd0, imm_seen}, 8'd4);
      chk("lui_srca", {6'd0, alusrca_e}, 8'd2);
      step(T_AU, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("auipc_srca", {6'd0, alusrca_e}, 8'd1);
      step(T_JR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("jalr_tgt", {7'd0, pctgtsrc_e}, 8'd1);
      chk("jalr_res", {6'd0, resultsrc_e}, 8'd2);
      step(T_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("jalr_pcsrc", {7'd0, pcsrc_seen}, 8'd1);

      // lw flushed, then sw reaches M two cycles after D
      step(T_LD, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("flush_res", {6'd0, resultsrc_e}, 8'd0);
      chk("flush_srcb", {7'd0, alusrcb_e}, 8'd0);
      step(T_ST, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(T_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sw_memwrite_m", {7'd0, memwrite_m}, 8'd1);

      // illegal opcode travels as a flagged bubble
      step(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ill_d", {7'd0, ill_seen}, 8'd1);
      step(T_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ill_regwrite_m", {7'd0, regwrite_m}, 8'd0);
      chk("ill_memwrite_m", {7'd0, memwrite_m}, 8'd0);
      step(T_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ill_w", {7'd0, illegal_w}, 8'd1);
      chk("ill_regwrite_w", {7'd0, regwrite_w}, 8'd0);

      // reset kills a store in M
      step(T_ST, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(T_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sw_in_m", {7'd0, memwrite_m}, 8'd1);
      step(T_I, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_kill_mw", {7'd0, memwrite_m}, 8'd0);
      chk("rst_kill_rw", {7'd0, regwrite_w}, 8'd0);

      // reset together with flush
      step(T_JL, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rstfl_res", {6'd0, resultsrc_e}, 8'd0);
      chk("rstfl_regwrite_m", {7'd0, regwrite_m}, 8'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [6:0] op;
         op = op_pool[$urandom_range(0, 9)];
         if (op == 7'd0) op = 7'($urandom_range(0, 127));
         step(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
